// File: rtl/l1_dcache_ctrl_pkg.sv
// ============================================================================
// Module : l1_dcache_ctrl_pkg
// Brief  : Shared FSM encodings, parameter defaults and address-field helpers
//          for the L1 data cache controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package l1_dcache_ctrl_pkg;

    localparam int c_NUM_LINES_DEF   = 64;
    localparam int c_BLOCK_WORDS_DEF = 4;
    localparam int c_ADDR_W_DEF      = 32;

    // Bits [1:0] select a byte within a 32-bit word; the word select starts here.
    localparam int c_WORD_LSB = 2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2
    } state_t;

    function automatic int idx_lsb(input int block_words);
        return c_WORD_LSB + $clog2(block_words);
    endfunction

    function automatic int tag_lsb(input int block_words, input int num_lines);
        return idx_lsb(block_words) + $clog2(num_lines);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_storage_array.sv
// ============================================================================
// Module : dcache_storage_array
// Brief  : Valid/dirty/tag/data registers for a direct-mapped cache with a
//          single read port, byte-masked word write and full-block fill.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dcache_storage_array #(
    parameter int NUM_LINES   = 64,
    parameter int BLOCK_WORDS = 4,
    parameter int TAG_W       = 22
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [$clog2(NUM_LINES)-1:0]  i_idx,
    output logic                          o_valid,
    output logic                          o_dirty,
    output logic [TAG_W-1:0]              o_tag,
    output logic [32*BLOCK_WORDS-1:0]     o_line,
    input  logic                          i_wr_en,
    input  logic [$clog2(BLOCK_WORDS)-1:0] i_wr_word,
    input  logic [31:0]                   i_wr_data,
    input  logic [3:0]                    i_wr_be,
    input  logic                          i_fill_en,
    input  logic [TAG_W-1:0]              i_fill_tag,
    input  logic [32*BLOCK_WORDS-1:0]     i_fill_data,
    input  logic                          i_clean_en
);

    localparam int c_LINE_W = 32 * BLOCK_WORDS;

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [c_LINE_W-1:0]  r_data [NUM_LINES];
    logic [c_LINE_W-1:0]  w_merged;

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];

    always_comb begin
        w_merged = r_data[i_idx];
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            for (int b = 0; b < 4; b++) begin
                if ((int'(i_wr_word) == w) && i_wr_be[b]) begin
                    w_merged[w*32 + b*8 +: 8] = i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    // A store marks the line dirty even with no byte lanes enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_en) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_wr_en) begin
            r_dirty[i_idx] <= 1'b1;
        end else if (i_clean_en) begin
            r_dirty[i_idx] <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_fill_en) begin
            r_tag[i_idx]  <= i_fill_tag;
            r_data[i_idx] <= i_fill_data;
        end else if (i_wr_en) begin
            r_data[i_idx] <= w_merged;
        end
    end

endmodule

`default_nettype wire

// File: rtl/l1_dcache_ctrl.sv
// ============================================================================
// Module : l1_dcache_ctrl
// Brief  : Direct-mapped, write-back, write-allocate L1 data cache with
//          single-cycle hits and a block handshake to main memory on misses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module l1_dcache_ctrl
    import l1_dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES   = c_NUM_LINES_DEF,
    parameter int BLOCK_WORDS = c_BLOCK_WORDS_DEF,
    parameter int ADDR_W      = c_ADDR_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cpu_ren,
    input  logic                      cpu_wen,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic [3:0]                cpu_be,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_stall,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [32*BLOCK_WORDS-1:0] mem_wdata,
    input  logic [32*BLOCK_WORDS-1:0] mem_rdata,
    input  logic                      mem_ready
);

    localparam int c_WSEL_W  = $clog2(BLOCK_WORDS);
    localparam int c_IDX_W   = $clog2(NUM_LINES);
    localparam int c_IDX_LSB = idx_lsb(BLOCK_WORDS);
    localparam int c_TAG_LSB = tag_lsb(BLOCK_WORDS, NUM_LINES);
    localparam int c_TAG_W   = ADDR_W - c_TAG_LSB;
    localparam int c_LINE_W  = 32 * BLOCK_WORDS;

    logic [c_TAG_W-1:0]    w_tag;
    logic [c_IDX_W-1:0]    w_idx;
    logic [c_WSEL_W-1:0]   w_word;
    logic [c_WORD_LSB-1:0] w_unused_byte;
    logic                  w_valid;
    logic                  w_dirty;
    logic [c_TAG_W-1:0]    w_line_tag;
    logic [c_LINE_W-1:0]   w_line;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_idle_hit;
    logic                  w_wr_en;
    logic                  w_fill_en;
    logic                  w_clean_en;
    logic [ADDR_W-1:0]     w_victim_addr;
    logic [ADDR_W-1:0]     w_fill_addr;

    state_t                r_state;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [c_LINE_W-1:0]   r_mem_wdata;

    assign w_tag         = cpu_addr[ADDR_W-1:c_TAG_LSB];
    assign w_idx         = cpu_addr[c_TAG_LSB-1:c_IDX_LSB];
    assign w_word        = cpu_addr[c_IDX_LSB-1:c_WORD_LSB];
    assign w_unused_byte = cpu_addr[c_WORD_LSB-1:0];

    assign w_req      = cpu_ren | cpu_wen;
    assign w_hit      = w_valid && (w_line_tag == w_tag);
    assign w_idle_hit = (r_state == S_IDLE) && w_hit;

    assign cpu_stall = w_req && !w_idle_hit;
    // A combined read+write request is a store, so no load data is returned.
    assign cpu_rdata = (cpu_ren && !cpu_wen && w_idle_hit) ? w_line[{w_word, 5'd0} +: 32] : '0;

    assign w_wr_en    = cpu_wen && w_idle_hit;
    assign w_fill_en  = (r_state == S_REFILL) && r_mem_req && mem_ready;
    assign w_clean_en = (r_state == S_WRITEBACK) && mem_ready;

    assign w_victim_addr = {w_line_tag, w_idx, {c_IDX_LSB{1'b0}}};
    assign w_fill_addr   = {w_tag, w_idx, {c_IDX_LSB{1'b0}}};

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    dcache_storage_array #(
        .NUM_LINES   (NUM_LINES),
        .BLOCK_WORDS (BLOCK_WORDS),
        .TAG_W       (c_TAG_W)
    ) u_storage (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_idx       (w_idx),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_line_tag),
        .o_line      (w_line),
        .i_wr_en     (w_wr_en),
        .i_wr_word   (w_word),
        .i_wr_data   (cpu_wdata),
        .i_wr_be     (cpu_be),
        .i_fill_en   (w_fill_en),
        .i_fill_tag  (w_tag),
        .i_fill_data (mem_rdata),
        .i_clean_en  (w_clean_en)
    );

    // After a writeback, mem_req drops for one cycle so the refill starts as a
    // distinct transaction; REFILL re-raises it before honouring mem_ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && !w_hit) begin
                        r_mem_req <= 1'b1;
                        if (w_valid && w_dirty) begin
                            r_state     <= S_WRITEBACK;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_victim_addr;
                            r_mem_wdata <= w_line;
                        end else begin
                            r_state    <= S_REFILL;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_fill_addr;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ready) begin
                        r_state    <= S_REFILL;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_fill_addr;
                    end
                end
                S_REFILL: begin
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                    end else if (mem_ready) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_l1_dcache_ctrl.sv
// ============================================================================
// Module : tb_l1_dcache_ctrl
// Brief  : Directed scoreboard bench for l1_dcache_ctrl with a small memory
//          responder driven from expected-transaction queues.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_l1_dcache_ctrl;

    logic         clock;
    logic         reset;
    logic         cpu_ren;
    logic         cpu_wen;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_be;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] data;
    } txn_t;

    txn_t        exp_mem[$];
    logic [31:0] exp_rd[$];
    int          n_checks;
    int          n_err;

    l1_dcache_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_ren   (cpu_ren),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] blk(input logic [31:0] w3, input logic [31:0] w2,
                                         input logic [31:0] w1, input logic [31:0] w0);
        return {w3, w2, w1, w0};
    endfunction

    task automatic push_txn(input logic we, input logic [31:0] addr, input logic [127:0] data);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data;
        exp_mem.push_back(t);
    endtask

    // Drives one CPU access, serves any memory transactions from exp_mem with
    // mem_ready on the lat-th cycle of each request, and checks the outcome.
    task automatic access(input bit st, input bit both, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input int lat,
                          input int exp_stalls, input int exp_txns);
        int   stalls = 0;
        int   txns   = 0;
        int   cnt    = 0;
        bit   in_txn = 0;
        bit   done   = 0;
        txn_t cur;
        logic [31:0] e;
        cur.we = 0; cur.addr = 0; cur.data = 0;
        @(negedge clock);
        cpu_ren   = !st || both;
        cpu_wen   = st;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_be    = be;
        mem_ready = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cyc > 0) begin
                @(negedge clock);
                mem_ready = 1'b0;
            end
            #1;
            if (!cpu_stall) begin
                if (!st) begin
                    if (exp_rd.size() == 0) chk("rdata_queue_empty", 1, 0);
                    else begin
                        e = exp_rd.pop_front();
                        chk("rdata", cpu_rdata, e);
                    end
                end
                done = 1;
            end else begin
                stalls++;
                if (mem_req) begin
                    if (!in_txn) begin
                        in_txn = 1;
                        cnt    = 0;
                        txns++;
                        if (exp_mem.size() == 0) chk("unexpected_mem_req", 1, 0);
                        else cur = exp_mem.pop_front();
                        if (cur.we) chk("wb_wdata", mem_wdata, cur.data);
                    end
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_we", mem_we, cur.we);
                    cnt++;
                    if (cnt == lat) begin
                        mem_ready = 1'b1;
                        if (!cur.we) mem_rdata = cur.data;
                    end
                end else begin
                    in_txn = 0;
                end
            end
        end
        if (!done) chk("access_timeout", 1, 0);
        chk("stall_cycles", stalls, exp_stalls);
        chk("mem_txns", txns, exp_txns);
        @(posedge clock);
        #1;
        cpu_ren   = 1'b0;
        cpu_wen   = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp, input int lat,
                        input int stalls, input int txns);
        exp_rd.push_back(exp);
        access(0, 0, a, 32'h0, 4'h0, lat, stalls, txns);
    endtask

    initial begin
        bit found;
        n_checks  = 0;
        n_err     = 0;
        reset     = 1'b1;
        cpu_ren   = 1'b0;
        cpu_wen   = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_be    = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        repeat (2) @(negedge clock);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        reset = 1'b0;

        // Cold load, then a hit on the neighbouring word.
        push_txn(0, 32'h40, blk(32'h44, 32'h33, 32'h22, 32'h11));
        load(32'h40, 32'h11, 1, 2, 1);
        load(32'h44, 32'h22, 0, 0, 0);

        // Half-word store hit merges into the refilled word.
        access(1, 0, 32'h40, 32'hAABBCCDD, 4'b0011, 0, 0, 0);
        load(32'h40, 32'h0000CCDD, 0, 0, 0);

        // Dirty eviction: writeback of merged line, then refill.
        push_txn(1, 32'h40, blk(32'h44, 32'h33, 32'h22, 32'h0000CCDD));
        push_txn(0, 32'h440, blk(32'h88, 32'h77, 32'h66, 32'h55));
        load(32'h440, 32'h55, 2, 6, 2);
        load(32'h44C, 32'h88, 0, 0, 0);

        // Clean eviction: refill only.
        push_txn(0, 32'h840, blk(32'hC4, 32'hC3, 32'hC2, 32'hC1));
        load(32'h840, 32'hC1, 1, 2, 1);

        // Slow memory: ready after 7 request cycles.
        push_txn(0, 32'hC40, blk(32'hD4, 32'hD3, 32'hD2, 32'hD1));
        load(32'hC40, 32'hD1, 7, 8, 1);

        // Store miss allocates, then the store merges on replay.
        push_txn(0, 32'h1080, blk(32'h4, 32'h3, 32'h2, 32'h1));
        access(1, 0, 32'h1084, 32'hDEADBEEF, 4'hF, 3, 4, 1);
        load(32'h1084, 32'hDEADBEEF, 0, 0, 0);
        load(32'h1088, 32'h3, 0, 0, 0);

        // Spurious mem_ready while idle must be ignored.
        @(negedge clock);
        mem_ready = 1'b1;
        @(negedge clock);
        mem_ready = 1'b0;
        #1;
        chk("spurious_mem_req", mem_req, 0);
        chk("spurious_stall", cpu_stall, 0);
        load(32'hC40, 32'hD1, 0, 0, 0);

        // Read and write together behave as a store.
        access(1, 1, 32'hC44, 32'h12345678, 4'hF, 0, 0, 0);
        load(32'hC44, 32'h12345678, 0, 0, 0);

        // Reset while a refill is outstanding.
        @(negedge clock);
        cpu_ren  = 1'b1;
        cpu_addr = 32'h2000;
        found    = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            #1;
            if (mem_req) found = 1;
        end
        chk("abort_req_seen", found, 1);
        chk("abort_mem_addr", mem_addr, 32'h2000);
        @(negedge clock);
        reset   = 1'b1;
        cpu_ren = 1'b0;
        @(negedge clock);
        #1;
        chk("abort_mem_req_dropped", mem_req, 0);
        chk("abort_stall", cpu_stall, 0);
        reset = 1'b0;

        // Previously dirty line is gone: clean refill, no writeback.
        push_txn(0, 32'hC40, blk(32'hE4, 32'hE3, 32'hE2, 32'hE1));
        load(32'hC40, 32'hE1, 1, 2, 1);
        push_txn(0, 32'h2000, blk(32'hF4, 32'hF3, 32'hF2, 32'hF1));
        load(32'h2000, 32'hF1, 2, 3, 1);

        chk("mem_queue_drained", exp_mem.size(), 0);
        chk("rdata_queue_drained", exp_rd.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/l1_dcache_ctrl.md
Name: l1_dcache_ctrl

Overview:
- Data-side L1 cache that responds to the MEM-stage load/store requests produced by the ID-stage main control (MemRead/MemWrite). It is the responder end of that request interface.
- Direct-mapped, write-back, write-allocate; single-cycle hits.
- Misses stall the pipeline and run a block handshake to main memory.

Parameters:
- NUM_LINES, 64, number of cache lines (power of 2).
- BLOCK_WORDS, 4, 32-bit words per line (power of 2).
- ADDR_W, 32, byte-address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_ren  in  1  load request (MemRead from EX/MEM).
- cpu_wen  in  1  store request (MemWrite from EX/MEM).
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data.
- cpu_be  in  4  store byte enables.
- cpu_rdata  out  32  load data, valid when a hit completes.
- cpu_stall  out  1  freeze pipeline.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = writeback, 0 = refill.
- mem_addr  out  ADDR_W  block-aligned address.
- mem_wdata  out  32*BLOCK_WORDS  victim block.
- mem_rdata  in  32*BLOCK_WORDS  refill block.
- mem_ready  in  1  one-cycle completion pulse.

Behaviour:
- Address split, defaults: byte [1:0]; word [3:2]; index [9:4]; tag [31:10]. Widths derive from the parameters.
- Storage per line: valid, dirty, tag, data. Arrays are registers.
- Reset:
  - All valid and dirty bits clear; FSM goes to IDLE.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0, cpu_rdata=0.
  - Data array contents are don't-care.
- hit = valid[idx] && tag[idx]==req_tag.
- cpu_stall = (cpu_ren|cpu_wen) && !(state==IDLE && hit). This is combinational, in the same cycle as the request.
- Load hit: cpu_rdata = selected word, combinational, zero-latency. Sub-word extraction is done downstream.
- Store hit: at the clock edge, write bytes selected by cpu_be into the word and set dirty. cpu_be=0 is a legal no-op, and the dirty bit is still set.
- cpu_ren && cpu_wen together: treated as a store.
- No request: FSM idles and makes no array change.
- FSM states:
  - IDLE: on miss, go to WRITEBACK if valid && dirty, else REFILL.
  - WRITEBACK:
    - Drives mem_req=1, mem_we=1, mem_addr={old tag, idx, 0}, mem_wdata=line data.
    - On mem_ready: clear dirty, go to REFILL.
  - REFILL:
    - Drives mem_req=1, mem_we=0, mem_addr={req tag, idx, 0}.
    - On mem_ready: write mem_rdata into the line, set tag and valid, clear dirty, go to IDLE.
  - Next cycle in IDLE the request hits and completes normally (load data returned, or store merged and dirty set).
- Miss latency: 1 (detect) + memory cycles + 1 (replay hit).
- mem_req stays high and mem_addr/mem_we/mem_wdata stay stable until mem_ready. mem_req drops in the cycle after mem_ready is sampled.
- mem_ready while mem_req=0 is ignored.
- The pipeline holds cpu_* stable while cpu_stall=1. Changes during a stall are undefined.
- Reset mid-miss: the transaction is abandoned and mem_req drops the next cycle. The memory model must tolerate this. The line is left invalid.
- Conflicting index with a different tag replaces the line. No associativity.

Decomposition:
- Shared package/header (alongside constants.v/config.vh): FSM state encodings (IDLE, WRITEBACK, REFILL), the defaults for the three parameters, and the address field bit positions.
- One natural sub-module, dcache_storage_array: valid/dirty/tag/data registers with read port, byte-masked word write, and full-block fill. The FSM and hit logic stay in l1_dcache_ctrl.

Test Plan:
- Cold load 0x0000_0040, memory returns block {0x44,0x33,0x22,0x11}:
  - Expect stall, then REFILL with mem_addr=0x40 and mem_we=0.
  - After mem_ready: cpu_rdata=0x11 and stall drops.
  - Repeat load to 0x44: hits with zero stall and returns 0x22.
- Store hit: store 0xAABBCCDD with be=4'b0011 to 0x40, then load 0x40.
  - Expect 0x0000CCDD (upper half zero from refill) and dirty=1.
- Dirty eviction: with 0x40 dirty, load 0x0000_0440 (same index, new tag).
  - Expect WRITEBACK at mem_addr=0x40 carrying the merged word, then REFILL at 0x440.
  - Exactly two mem_req transactions.
- Clean eviction: load 0x840 after a clean fill of the same index.
  - Expect no writeback; REFILL only.
- Memory latency: mem_ready delayed 7 cycles.
  - mem_req and mem_addr stay stable throughout; stall stays high for all cycles.
  - A spurious mem_ready in IDLE causes no state change.
- Reset during REFILL:
  - mem_req=0 the cycle after reset.
  - A subsequent load to the same address misses again (valid cleared).
